// File: rtl/tick_pipeline.sv
// Elastic STAGES-deep pipeline whose stages advance on a divide-by-DIV tick enable.
// Define PIPE_STALL_CNT_EN to add a saturating output-stall counter port (stall_cnt).
module tick_pipeline #(
    parameter int DATA_W = 8,
    parameter int STAGES = 3,
    parameter int DIV    = 4,
    parameter int STEP   = 1
) (
    input  logic                        fast_clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic                        slow_tick,
`ifdef PIPE_STALL_CNT_EN
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [15:0]                 stall_cnt
`else
    output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

    localparam int                CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int                OCC_W   = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [DATA_W-1:0] STEP_W  = DATA_W'(STEP);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [DATA_W-1:0] d_q [STAGES];
    logic [DATA_W-1:0] d_d [STAGES];
    logic [STAGES-1:0] free;
    logic              pop;
    logic              accept;

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    assign slow_tick = (cnt_q == CNT_MAX) && !rst;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign pop       = v_q[STAGES-1] && out_ready;
    assign in_ready  = slow_tick && free[0] && !rst;
    assign accept    = in_valid && in_ready;

    // A stage is free if empty or if it will drain this cycle; the last stage drains on pop
    // at any cycle, inner stages only on a tick, so out_ready ripples back to in_ready.
    always_comb begin : free_chain
        logic [STAGES-1:0] f;
        f = '0;
        f[STAGES-1] = !v_q[STAGES-1] || pop;
        for (int i = STAGES - 2; i >= 0; i--) begin
            f[i] = !v_q[i] || (slow_tick && f[i+1]);
        end
        free = f;
    end

    always_comb begin : stage_next
        logic [STAGES-1:0] fill;
        logic [STAGES-1:0] leave;
        fill  = '0;
        leave = '0;
        v_d   = v_q;
        for (int i = 0; i < STAGES; i++) begin
            d_d[i] = d_q[i];
        end

        fill[0] = accept;
        if (accept) begin
            d_d[0] = in_data;
        end

        for (int i = 0; i < STAGES - 1; i++) begin
            if (slow_tick && v_q[i] && free[i+1]) begin
                leave[i]   = 1'b1;
                fill[i+1]  = 1'b1;
                d_d[i+1]   = d_q[i] + STEP_W;
            end
        end
        leave[STAGES-1] = pop;

        // A refill wins over a departure, so pop-and-refill keeps the stage valid.
        for (int i = 0; i < STAGES; i++) begin
            v_d[i] = fill[i] || (v_q[i] && !leave[i]);
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            v_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            v_q   <= v_d;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_tick_pipeline.sv
// Scoreboard bench for tick_pipeline (DATA_W=8, STAGES=3, DIV=4, STEP=1): the driver queues
// hand-computed results on acceptance and a negedge monitor checks them as they emerge.
`timescale 1ns/1ps
module tb_tick_pipeline;

    localparam int DATA_W = 8;
    localparam int STAGES = 3;
    localparam int DIV    = 4;
    localparam int STEP   = 1;

    logic              fast_clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              slow_tick;
    logic [1:0]        occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int                checks       = 0;
    int                failures     = 0;
    int                outputs_seen = 0;
    logic [DATA_W-1:0] exp_q [$];

    tick_pipeline #(
        .DATA_W (DATA_W),
        .STAGES (STAGES),
        .DIV    (DIV),
        .STEP   (STEP)
    ) dut (
        .fast_clk  (fast_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .slow_tick (slow_tick),
`ifdef PIPE_STALL_CNT_EN
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
`else
        .occupancy (occupancy)
`endif
    );

    always #5 fast_clk = ~fast_clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Every completed output handshake must match the oldest queued expectation.
    always @(negedge fast_clk) begin
        if (out_valid && out_ready) begin
            outputs_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output actual=%0d expected=none", out_data);
            end else begin
                checkOutput("out_data", longint'(out_data), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] expected,
                                 input int max_wait, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = data;
        @(negedge fast_clk);
        while (!in_ready && waited < max_wait) begin
            @(negedge fast_clk);
            waited++;
        end
        checkOutput("accept", longint'(in_ready), 1);
        if (in_ready) begin
            exp_q.push_back(expected);
        end
        @(posedge fast_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainCheck(input string name);
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge fast_clk);
            waited++;
        end
        checkOutput(name, exp_q.size(), 0);
        @(posedge fast_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int w;
        int bad_ready;
        int bad_data;
        int seen_before;
`ifdef PIPE_STALL_CNT_EN
        logic [15:0] stall_start;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge fast_clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_slow_tick", slow_tick, 0);
`ifdef PIPE_STALL_CNT_EN
        checkOutput("rst_stall_cnt", stall_cnt, 0);
`endif

        @(posedge fast_clk);
        #1;
        rst = 1'b0;
        $display("[TB] idle after reset release");
        for (int k = 1; k <= 12; k++) begin
            @(negedge fast_clk);
            checkOutput("idle_slow_tick", slow_tick, (k % 4 == 0) ? 1 : 0);
            checkOutput("idle_occupancy", occupancy, 0);
        end
        @(posedge fast_clk);
        #1;

        $display("[TB] single item");
        applyStimulus(8'd10, 8'd12, 3, w);
        checkOutput("single_wait", w, 3);
        for (int j = 1; j <= 10; j++) begin
            @(negedge fast_clk);
            checkOutput("single_out_valid", out_valid, (j == 9) ? 1 : 0);
        end
        drainCheck("single_drain");

        $display("[TB] stream");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'(i), 8'(i + 2), 3, w);
        end
        drainCheck("stream_drain");

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'd1, 8'd3, 3, w);
        applyStimulus(8'd2, 8'd4, 3, w);
        applyStimulus(8'd3, 8'd5, 3, w);
        in_valid  = 1'b1;
        in_data   = 8'd4;
        bad_ready = 0;
        bad_data  = 0;
        @(negedge fast_clk);
`ifdef PIPE_STALL_CNT_EN
        stall_start = stall_cnt;
`endif
        for (int j = 2; j <= 12; j++) begin
            @(negedge fast_clk);
            if (in_ready) bad_ready++;
            if (out_data != 8'd3 || !out_valid) bad_data++;
        end
        checkOutput("bp_in_ready_cycles", bad_ready, 0);
        checkOutput("bp_out_unstable_cycles", bad_data, 0);
        checkOutput("bp_occupancy", occupancy, 3);
        checkOutput("bp_out_data", out_data, 3);
`ifdef PIPE_STALL_CNT_EN
        checkOutput("bp_stall_delta", stall_cnt - stall_start, 11);
`endif
        @(posedge fast_clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(8'd4, 8'd6, 3, w);
        applyStimulus(8'd5, 8'd7, 3, w);
        drainCheck("bp_drain");

        $display("[TB] wrap");
        applyStimulus(8'd255, 8'd1, 3, w);
        applyStimulus(8'd254, 8'd0, 3, w);
        drainCheck("wrap_drain");

        $display("[TB] reset mid-flight");
        applyStimulus(8'd20, 8'd22, 3, w);
        applyStimulus(8'd21, 8'd23, 3, w);
        @(negedge fast_clk);
        checkOutput("mid_occupancy_before", occupancy, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_occupancy_async", occupancy, 0);
        checkOutput("mid_out_valid_async", out_valid, 0);
        exp_q.delete();
        repeat (2) begin
            @(posedge fast_clk);
            #1;
        end
        rst = 1'b0;
        seen_before = outputs_seen;
        repeat (16) @(negedge fast_clk);
        checkOutput("mid_no_output", outputs_seen - seen_before, 0);
        checkOutput("mid_occupancy_after", occupancy, 0);
        @(posedge fast_clk);
        #1;
        applyStimulus(8'd7, 8'd9, 3, w);
        drainCheck("mid_drain");

        checkOutput("total_outputs", outputs_seen, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
